// File: rtl/wall_probe_scheduler_pkg.sv
// wall_probe_scheduler_pkg: shared constants, FSM states and the 12-entry probe offset table
package wall_probe_scheduler_pkg;
  localparam int N_REQ = 4;
  localparam int COORD_W = 9;
  localparam int ID_W = $clog2(N_REQ);
  typedef logic signed [COORD_W:0] off_t;
  typedef enum logic [1:0] {IDLE, PROBE, DRAIN, DONE} state_t;
  typedef struct packed {
    off_t dx;
    off_t dy;
  } probe_t;
  localparam logic [3:0] DIR_L = 4'b1000;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_D = 4'b0001;
  localparam logic [1:0] WALL = 2'b00;
  localparam logic [COORD_W-1:0] MAP_LU_X = '0;
  localparam logic [COORD_W-1:0] MAP_LU_Y = '0;
  localparam logic [COORD_W-1:0] MAP_W = COORD_W'(348);
  localparam logic [COORD_W-1:0] MAP_H = COORD_W'(408);
  localparam off_t ZERO = off_t'(0);
  localparam off_t NEAR = off_t'(11);
  localparam off_t FAR_N = off_t'(13);
  localparam off_t FAR_P = off_t'(12);
  function automatic probe_t probe_off(input logic [3:0] k);
    case (k)
      4'd0: return '{-FAR_N, ZERO};
      4'd1: return '{-NEAR, -FAR_N};
      4'd2: return '{-NEAR, FAR_P};
      4'd3: return '{ZERO, -FAR_N};
      4'd4: return '{-FAR_N, -NEAR};
      4'd5: return '{FAR_P, -NEAR};
      4'd6: return '{FAR_P, ZERO};
      4'd7: return '{NEAR, -FAR_N};
      4'd8: return '{NEAR, FAR_P};
      4'd9: return '{ZERO, FAR_P};
      4'd10: return '{-FAR_N, NEAR};
      4'd11: return '{FAR_P, NEAR};
      default: return '{ZERO, ZERO};
    endcase
  endfunction
  function automatic logic [3:0] dir_of(input logic [3:0] k);
    return k < 4'd3 ? DIR_L : k < 4'd6 ? DIR_U : k < 4'd9 ? DIR_R : DIR_D;
  endfunction
endpackage

// File: rtl/wall_probe_scheduler_if.sv
// wall_probe_scheduler_if: agent request/response and mapRom lookup signals
interface wall_probe_scheduler_if;
  import wall_probe_scheduler_pkg::*;
  logic [N_REQ-1:0] req;
  logic [N_REQ*COORD_W-1:0] req_x;
  logic [N_REQ*COORD_W-1:0] req_y;
  logic [COORD_W-1:0] rom_x;
  logic [COORD_W-1:0] rom_y;
  logic [1:0] rom_pixel;
  logic [N_REQ-1:0] done;
  logic [3:0] flags;
  logic busy;
  modport master(output req, req_x, req_y, rom_pixel, input rom_x, rom_y, done, flags, busy);
  modport slave(input req, req_x, req_y, rom_pixel, output rom_x, rom_y, done, flags, busy);
endinterface

// File: rtl/wall_probe_scheduler_rr_arbiter.sv
// wall_probe_scheduler_rr_arbiter: first set request at or after ptr, wrapping
module wall_probe_scheduler_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (req[W'((int'(ptr) + i) % N)]) begin
        idx = W'((int'(ptr) + i) % N);
        any = 1'b1;
      end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/wall_probe_scheduler.sv
// wall_probe_scheduler: shares one mapRom port among agents, running a 12-probe wall check per request
module wall_probe_scheduler
  import wall_probe_scheduler_pkg::*;
(
  input logic clk,
  input logic reset,
  wall_probe_scheduler_if.slave bus
);
  state_t state;
  logic [ID_W-1:0] ptr, id, gidx;
  logic [N_REQ-1:0] sel, gnt;
  logic any;
  logic [3:0] k, sk, mask;
  logic [COORD_W-1:0] cx, cy;
  logic sv, sblk, blk, pass;
  probe_t off;
  off_t px, py;
  wall_probe_scheduler_rr_arbiter #(.N(N_REQ), .W(ID_W)) u_arb (
    .req(bus.req), .ptr(ptr), .gnt(gnt), .idx(gidx), .any(any)
  );
  // Sign bit catches underflow; the low bits still go to the ROM unchanged.
  always_comb begin
    off = probe_off(k);
    px = off_t'({1'b0, cx}) + off.dx;
    py = off_t'({1'b0, cy}) + off.dy;
    blk = px[COORD_W] | py[COORD_W] | (px[COORD_W-1:0] >= MAP_W) | (py[COORD_W-1:0] >= MAP_H);
    pass = ~sblk & (bus.rom_pixel != WALL);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      sel <= '0;
      k <= '0;
      sk <= '0;
      cx <= '0;
      cy <= '0;
      mask <= '0;
      sv <= 1'b0;
      sblk <= 1'b0;
      bus.rom_x <= '0;
      bus.rom_y <= '0;
      bus.done <= '0;
      bus.flags <= '0;
      bus.busy <= 1'b0;
    end else begin
      bus.done <= '0;
      sv <= state == PROBE;
      if (sv) mask <= mask & ~(pass ? 4'b0000 : dir_of(sk));
      case (state)
        IDLE: if (any) begin
          id <= gidx;
          sel <= gnt;
          cx <= bus.req_x[int'(gidx)*COORD_W +: COORD_W];
          cy <= bus.req_y[int'(gidx)*COORD_W +: COORD_W];
          mask <= 4'b1111;
          k <= '0;
          bus.busy <= 1'b1;
          state <= PROBE;
        end
        PROBE: begin
          bus.rom_x <= px[COORD_W-1:0];
          bus.rom_y <= py[COORD_W-1:0];
          sblk <= blk;
          sk <= k;
          k <= k + 4'd1;
          if (k == 4'd11) state <= DRAIN;
        end
        DRAIN: state <= DONE;
        DONE: begin
          bus.done <= sel;
          bus.flags <= mask;
          bus.busy <= 1'b0;
          ptr <= id == ID_W'(N_REQ - 1) ? '0 : id + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wall_probe_scheduler.sv
// tb_wall_probe_scheduler: directed scoreboard bench with a behavioural mapRom
module tb_wall_probe_scheduler;
  import wall_probe_scheduler_pkg::*;
  typedef struct packed {
    logic [3:0] done;
    logic [3:0] flags;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;
  exp_t sb[$];
  wall_probe_scheduler_if bus();
  wall_probe_scheduler dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic is_wall(input int x, input int y);
    return x < 12 || y < 12 || x >= 336 || y >= 396;
  endfunction
  assign bus.rom_pixel = is_wall(int'(bus.rom_x), int'(bus.rom_y)) ? 2'b00 : 2'b01;
  function automatic logic [3:0] model(input int x, input int y);
    int dx[12] = '{-13, -11, -11, 0, -13, 12, 12, 11, 11, 0, -13, 12};
    int dy[12] = '{0, -13, 12, -13, -11, -11, 0, -13, 12, 12, 11, 11};
    logic [3:0] m;
    int px, py;
    m = 4'hF;
    for (int j = 0; j < 12; j++) begin
      px = x + dx[j];
      py = y + dy[j];
      if (px < 0 || py < 0 || px >= 348 || py >= 408 || is_wall(px, py)) m[3 - j / 3] = 1'b0;
    end
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h (failures %0d)", tag, obs, exp, fail_cnt);
    end
  endtask
  task automatic set_xy(input int id, input int x, input int y);
    bus.req_x[id*COORD_W +: COORD_W] = COORD_W'(x);
    bus.req_y[id*COORD_W +: COORD_W] = COORD_W'(y);
  endtask
  task automatic expect_job(input int id, input int x, input int y);
    sb.push_back('{done: 4'(1 << id), flags: model(x, y)});
  endtask
  task automatic wait_done(input string tag, output int cyc, output logic b1);
    exp_t e;
    logic xs;
    xs = 1'b0;
    cyc = 0;
    b1 = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) b1 = bus.busy;
      xs |= $isunknown({bus.rom_x, bus.rom_y});
    end while (bus.done === 4'b0000 && cyc < 40);
    e = sb.size() > 0 ? sb.pop_front() : '{done: 4'b0000, flags: 4'b0000};
    chk({tag, "_done"}, 32'(bus.done), 32'(e.done));
    chk({tag, "_flags"}, 32'(bus.flags), 32'(e.flags));
    chk({tag, "_rom_known"}, 32'(xs), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int cyc;
    logic b1;
    logic [3:0] acc;
    bus.req = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_rom", 32'({bus.rom_x, bus.rom_y}), 0);
    chk("rst_out", 32'({bus.done, bus.flags, bus.busy}), 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_quiet", 32'({bus.done, bus.flags, bus.busy}), 0);
    end
    set_xy(0, 100, 100);
    set_xy(1, 20, 100);
    set_xy(2, 100, 20);
    set_xy(3, 340, 200);
    expect_job(0, 100, 100);
    expect_job(1, 20, 100);
    expect_job(2, 100, 20);
    expect_job(3, 340, 200);
    expect_job(0, 100, 100);
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_done("rr", cyc, b1);
      chk("rr_spacing", 32'(cyc), 15);
    end
    bus.req = '0;
    expect_job(0, 100, 100);
    bus.req = 4'b0001;
    wait_done("open", cyc, b1);
    chk("open_busy", 32'(b1), 1);
    chk("open_latency", 32'(cyc), 15);
    bus.req = '0;
    chk("open_busy_after", 32'(bus.busy), 0);
    set_xy(1, 20, 100);
    expect_job(1, 20, 100);
    bus.req = 4'b0010;
    wait_done("left_wall", cyc, b1);
    chk("left_wall_latency", 32'(cyc), 15);
    bus.req = '0;
    set_xy(1, 100, 20);
    expect_job(1, 100, 20);
    bus.req = 4'b0010;
    repeat (3) @(negedge clk);
    bus.req = '0;
    set_xy(1, 5, 5);
    wait_done("top_wall_drop", cyc, b1);
    chk("top_wall_latency", 32'(cyc + 3), 15);
    set_xy(2, 5, 5);
    expect_job(2, 5, 5);
    bus.req = 4'b0100;
    wait_done("negative", cyc, b1);
    chk("negative_latency", 32'(cyc), 15);
    bus.req = '0;
    set_xy(1, 200, 200);
    bus.req = 4'b0010;
    repeat (6) @(negedge clk);
    reset = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    chk("abort_out", 32'({bus.done, bus.flags, bus.busy}), 0);
    reset = 1'b0;
    acc = '0;
    repeat (20) begin
      @(negedge clk);
      acc |= bus.done;
    end
    chk("abort_no_done", 32'(acc), 0);
    set_xy(3, 100, 100);
    expect_job(3, 100, 100);
    bus.req = 4'b1000;
    wait_done("after_abort", cyc, b1);
    chk("after_abort_latency", 32'(cyc), 15);
    bus.req = '0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
